// File: rtl/mem_responder_pkg.sv
// Shared constants and address decode for the memory/IO responder.
package mem_responder_pkg;

  localparam int unsigned DEF_RAM_ADDR_W = 17;
  localparam int unsigned DEF_TX_DEPTH   = 16;

  localparam int unsigned IO_SEL_BIT   = 17;
  localparam logic [17:0] IO_DATA_ADDR = 18'h30000;
  localparam logic [17:0] IO_CTRL_ADDR = 18'h30004;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_IO_DATA,
    SEL_IO_CTRL,
    SEL_IO_NONE
  } sel_e;

  function automatic sel_e decode(input logic [17:0] a);
    if (!a[IO_SEL_BIT])    return SEL_RAM;
    if (a == IO_DATA_ADDR) return SEL_IO_DATA;
    if (a == IO_CTRL_ADDR) return SEL_IO_CTRL;
    return SEL_IO_NONE;
  endfunction

endpackage

// File: rtl/mem_responder_fifo.sv
// Synchronous FIFO with occupancy count; pointers wrap naturally (DEPTH is a power of 2).
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_responder.sv
// CPU-facing byte RAM plus memory-mapped TX/RX IO and a halt flag.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned RAM_ADDR_W = DEF_RAM_ADDR_W,
  parameter int unsigned TX_DEPTH   = DEF_TX_DEPTH
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        rdy_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        halt
);

  localparam int unsigned CW = $clog2(TX_DEPTH) + 1;

  logic [7:0]            ram [2**RAM_ADDR_W];
  logic [RAM_ADDR_W-1:0] ram_idx;
  sel_e                  sel;
  logic                  act;
  logic                  tx_full;
  logic                  tx_empty;
  logic [CW-1:0]         tx_count;
  logic                  tx_push;
  logic                  rd_data;
  logic [7:0]            rx_byte;
  logic                  rx_full;
  logic                  unused_ok;

  assign ram_idx  = mem_a[RAM_ADDR_W-1:0];
  assign sel      = decode(mem_a[17:0]);
  assign rdy_out  = ~tx_full;
  assign tx_valid = ~tx_empty;
  // A stalled bus is simply ignored; reset also suppresses any bus action.
  assign act      = rst_in & rdy_out;
  assign tx_push  = act & mem_wr & (sel == SEL_IO_DATA);
  assign rd_data  = act & ~mem_wr & (sel == SEL_IO_DATA);

  assign unused_ok = ^{mem_a[31:18], tx_count};

  always_ff @(posedge clk_in) begin
    if (act && mem_wr && sel == SEL_RAM) ram[ram_idx] <= mem_dout;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      mem_din <= '0;
      rx_byte <= '0;
      rx_full <= 1'b0;
      halt    <= 1'b0;
    end else begin
      if (act && !mem_wr) begin
        case (sel)
          SEL_RAM:     mem_din <= ram[ram_idx];
          SEL_IO_DATA: mem_din <= rx_full ? rx_byte : 8'h00;
          SEL_IO_CTRL: mem_din <= {6'b0, rx_full, tx_full};
          default:     mem_din <= 8'h00;
        endcase
      end
      if (act && mem_wr && sel == SEL_IO_CTRL) halt <= 1'b1;
      // A new byte wins over a concurrent read-clear; the read still sees the old byte.
      if (rx_valid) begin
        rx_byte <= rx_data;
        rx_full <= 1'b1;
      end else if (rd_data) begin
        rx_full <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (tx_push),
    .pop    (tx_valid & tx_ready),
    .din    (mem_dout),
    .dout   (tx_data),
    .full   (tx_full),
    .empty  (tx_empty),
    .count  (tx_count)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
module tb_mem_responder;

  localparam logic [31:0] IDLE_A = 32'h0003_0008;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        rdy_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        halt;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [7:0]  sink_q[$];

  mem_responder #(
    .RAM_ADDR_W (17),
    .TX_DEPTH   (16)
  ) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .mem_a    (mem_a),
    .mem_dout (mem_dout),
    .mem_wr   (mem_wr),
    .mem_din  (mem_din),
    .rdy_out  (rdy_out),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .halt     (halt)
  );

  always #5 clk_in = ~clk_in;

  // Bytes the sink will take on the coming edge.
  always @(negedge clk_in) begin
    if (rst_in && tx_valid && tx_ready) sink_q.push_back(tx_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
    int unsigned n = 0;
    mem_a = a; mem_wr = wr; mem_dout = d;
    while (!rdy_out && n < 100) begin
      @(posedge clk_in); #1;
      n++;
    end
    if (!rdy_out) check("bus_stall_timeout", 32'(rdy_out), 1);
    @(posedge clk_in); #1;
    mem_a = IDLE_A; mem_wr = 1'b0; mem_dout = 8'h00;
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] exp, input string tag);
    bus(a, 1'b0, 8'h00);
    check(tag, 32'(mem_din), 32'(exp));
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    @(posedge clk_in); #1;
    rx_valid = 1'b0;
  endtask

  task automatic cycles(input int unsigned k);
    repeat (k) begin
      @(posedge clk_in); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    rst_in = 1'b0; mem_a = IDLE_A; mem_dout = 8'h00; mem_wr = 1'b0;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    cycles(2);
    check("rst_mem_din", 32'(mem_din), 0);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_rdy", 32'(rdy_out), 1);
    check("rst_halt", 32'(halt), 0);
    rst_in = 1'b1;

    // RAM write/read, write leaves mem_din alone, high address bits ignored
    bus(32'h0000_0010, 1'b1, 8'hA5);
    rd(32'h0000_0010, 8'hA5, "ram_rd_10");
    bus(32'h0000_0011, 1'b1, 8'h3C);
    check("wr_keeps_din", 32'(mem_din), 32'hA5);
    rd(32'h0000_0011, 8'h3C, "ram_rd_11");
    rd(32'hFFFC_0011, 8'h3C, "ram_rd_alias");
    rd(32'h0001_FFFF, 8'h00, "ram_rd_top_pre");
    bus(32'h0001_FFFF, 1'b1, 8'h9E);
    rd(32'h0001_FFFF, 8'h9E, "ram_rd_top");

    // Unmapped IO: reads 0, writes do nothing
    bus(32'h0003_0008, 1'b1, 8'h55);
    rd(32'h0003_000C, 8'h00, "io_other_rd");
    check("io_other_no_tx", 32'(tx_valid), 0);
    check("io_other_no_halt", 32'(halt), 0);

    // Single TX byte with ready sink
    tx_ready = 1'b1; sink_q.delete();
    bus(32'h0003_0000, 1'b1, 8'h41);
    check("tx1_valid", 32'(tx_valid), 1);
    check("tx1_data", 32'(tx_data), 32'h41);
    cycles(1);
    check("tx1_popped", 32'(tx_valid), 0);
    check("tx1_sink_n", sink_q.size(), 1);
    check("tx1_sink_b", 32'(sink_q.size() > 0 ? sink_q[0] : 8'hxx), 32'h41);

    // Fill to full, stall the 17th write, then drain
    tx_ready = 1'b0; sink_q.delete();
    for (int i = 1; i <= 16; i++) bus(32'h0003_0000, 1'b1, 8'(i));
    check("full_rdy", 32'(rdy_out), 0);
    check("full_head", 32'(tx_data), 1);
    mem_a = 32'h0003_0000; mem_wr = 1'b1; mem_dout = 8'd17;
    cycles(3);
    check("stall_rdy", 32'(rdy_out), 0);
    check("stall_head", 32'(tx_data), 1);
    tx_ready = 1'b1;
    n = 0;
    while (!rdy_out && n < 20) begin
      cycles(1);
      n++;
    end
    check("stall_release", 32'(rdy_out), 1);
    cycles(1);
    mem_a = IDLE_A; mem_wr = 1'b0; mem_dout = 8'h00;
    cycles(25);
    check("drain_empty", 32'(tx_valid), 0);
    check("drain_count", sink_q.size(), 17);
    for (int i = 0; i < 17; i++)
      check($sformatf("drain_b%0d", i + 1),
            32'(i < sink_q.size() ? sink_q[i] : 8'hxx), 32'(i + 1));

    // RX holding register
    tx_ready = 1'b0;
    rx_pulse(8'h5A);
    rd(32'h0003_0004, 8'h02, "rx_status_full");
    rd(32'h0003_0000, 8'h5A, "rx_data");
    rd(32'h0003_0004, 8'h00, "rx_status_empty");
    rd(32'h0003_0000, 8'h00, "rx_data_empty");
    rx_pulse(8'h33);
    rx_pulse(8'h44);
    rd(32'h0003_0000, 8'h44, "rx_overwrite");
    rx_pulse(8'h11);
    rx_data = 8'h22; rx_valid = 1'b1;
    bus(32'h0003_0000, 1'b0, 8'h00);
    rx_valid = 1'b0;
    check("rx_race_old", 32'(mem_din), 32'h11);
    rd(32'h0003_0004, 8'h02, "rx_race_full");
    rd(32'h0003_0000, 8'h22, "rx_race_new");

    // Halt, queued bytes, then reset with a write on the bus
    bus(32'h0003_0004, 1'b1, 8'h00);
    check("halt_set", 32'(halt), 1);
    for (int i = 0; i < 3; i++) bus(32'h0003_0000, 1'b1, 8'(8'hC0 + i));
    check("pre_rst_valid", 32'(tx_valid), 1);
    rd(32'h0000_0010, 8'hA5, "pre_rst_din");
    sink_q.delete();
    rst_in = 1'b0; mem_a = 32'h0000_0010; mem_wr = 1'b1; mem_dout = 8'h77;
    cycles(1);
    rst_in = 1'b1; mem_a = IDLE_A; mem_wr = 1'b0; mem_dout = 8'h00;
    check("rst2_halt", 32'(halt), 0);
    check("rst2_tx_valid", 32'(tx_valid), 0);
    check("rst2_rdy", 32'(rdy_out), 1);
    check("rst2_din", 32'(mem_din), 0);
    tx_ready = 1'b1;
    cycles(3);
    check("rst2_no_tx", sink_q.size(), 0);
    rd(32'h0000_0010, 8'hA5, "rst2_ram_kept");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
